// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from the sync generator to the pixel client.
// master drives timing; slave is the consuming pixel pipeline.
interface vga_sync_gen_if;
    logic        HS;
    logic        VS;
    logic        HBlank;
    logic        VBlank;
    logic [10:0] CurrentX;
    logic [10:0] CurrentY;
    logic        PixelTick;
    logic        LineStart;
    logic        FrameStart;

    modport master (
        output HS, VS, HBlank, VBlank,
        output CurrentX, CurrentY,
        output PixelTick, LineStart, FrameStart
    );

    modport slave (
        input HS, VS, HBlank, VBlank,
        input CurrentX, CurrentY,
        input PixelTick, LineStart, FrameStart
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel-rate divider, X/Y counters
// and registered sync/blank/strobe flags decoded from the next position.
module vga_sync_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic           CLK_100MHz,
    input  logic           Reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ADV  = DW'(CLK_DIV - 2);
    localparam logic [10:0]   X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]   Y_LAST   = 11'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048 || CLK_DIV < 2) begin : g_bad_cfg
            $error("vga_sync_gen: timing parameters out of range");
        end
    endgenerate

    function automatic logic in_win(input logic [10:0] v, input int lo, input int hi);
        int vi;
        vi = int'(v);
        return (vi >= lo) && (vi < hi);
    endfunction

    logic [DW-1:0] div_q, div_nxt;
    logic [10:0]   x_q, y_q, x_nxt, y_nxt;
    logic          adv;
    logic          hs_q, vs_q, hb_q, vb_q;
    logic          pt_q, ls_q, fs_q;

    // Advance lands on the edge where div reaches its last value, so the
    // first step after reset comes CLK_DIV-1 clocks later.
    always_comb begin
        adv     = (div_q == DIV_ADV);
        div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        x_nxt   = x_q;
        y_nxt   = y_q;
        if (adv) begin
            if (x_q == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
            end else begin
                x_nxt = x_q + 11'd1;
            end
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hb_q  <= 1'b0;
            vb_q  <= 1'b0;
            hs_q  <= SYNC_ACTIVE_LOW;
            vs_q  <= SYNC_ACTIVE_LOW;
            pt_q  <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            pt_q  <= adv;
            ls_q  <= adv && (x_nxt == '0);
            fs_q  <= adv && (x_nxt == '0) && (y_nxt == '0);
            // Flags follow the position they are registered with.
            hb_q  <= int'(x_nxt) >= H_ACTIVE;
            vb_q  <= int'(y_nxt) >= V_ACTIVE;
            hs_q  <= in_win(x_nxt, HS_LO, HS_HI) ? ~SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
            vs_q  <= in_win(y_nxt, VS_LO, VS_HI) ? ~SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
        end
    end

    assign vga.HS         = hs_q;
    assign vga.VS         = vs_q;
    assign vga.HBlank     = hb_q;
    assign vga.VBlank     = vb_q;
    assign vga.CurrentX   = x_q;
    assign vga.CurrentY   = y_q;
    assign vga.PixelTick  = pt_q;
    assign vga.LineStart  = ls_q;
    assign vga.FrameStart = fs_q;
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Free-running VGA timing generator that sits directly upstream of the pixel client. It divides CLK_100MHz down to a pixel-rate enable and runs horizontal and vertical position counters. From these it produces the HS/VS sync pulses, the HBlank/VBlank flags and the CurrentX/CurrentY coordinates that the client consumes. Default timing is 640x480@60 Hz (25 MHz pixel rate from a 100 MHz clock).

Parameters:
CLK_DIV, 4, system clocks per pixel (≥2)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = HS/VS driven low during the pulse; 0 = driven high

Ports:
CLK_100MHz  input  1  system clock; all logic is on the rising edge
Reset  input  1  synchronous, active-high reset
HS  output  1  horizontal sync
VS  output  1  vertical sync
HBlank  output  1  high while CurrentX ≥ H_ACTIVE
VBlank  output  1  high while CurrentY ≥ V_ACTIVE
CurrentX  output  11  horizontal position, 0..H_TOTAL-1
CurrentY  output  11  vertical position, 0..V_TOTAL-1
PixelTick  output  1  one-clock strobe on the edge where the position advances
LineStart  output  1  one-clock strobe when CurrentX wraps to 0
FrameStart  output  1  one-clock strobe when (CurrentX,CurrentY) wraps to (0,0)

Behaviour:
- One clock (CLK_100MHz). Reset is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Both totals must be ≤ 2048. Elaboration fails otherwise.
- Divider: counter div runs 0..CLK_DIV-1 and wraps. An advance occurs on each edge where div == CLK_DIV-1.
- On an advance, CurrentX increments. At H_TOTAL-1 it wraps to 0.
- On an advance with CurrentX == H_TOTAL-1, CurrentY increments. At V_TOTAL-1 it wraps to 0.
- All outputs are registered. On each advance edge they are decoded from the next position, so HS/VS/HBlank/VBlank always agree with CurrentX/CurrentY in the same cycle. There is no extra pipeline latency between coordinates and flags.
- PixelTick is high for exactly the clock following an advance edge. Its period is CLK_DIV clocks.
- LineStart is high for that same clock when the new CurrentX == 0.
- FrameStart is high for that same clock when the new position is (0,0).
- Horizontal sync pulse is active for H_ACTIVE+H_FP ≤ CurrentX < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- Vertical sync pulse is active for V_ACTIVE+V_FP ≤ CurrentY < V_ACTIVE+V_FP+V_SYNC (490..491 by default). VS is line-based: it changes only when CurrentX wraps to 0.
- Sync level: active = ~SYNC_ACTIVE_LOW; inactive = SYNC_ACTIVE_LOW.
- Reset values: div=0; CurrentX=0; CurrentY=0; HBlank=0; VBlank=0; HS and VS at the inactive level; PixelTick=0; LineStart=0; FrameStart=0.
- First advance after reset release occurs CLK_DIV-1 clocks later and moves to (1,0). Position (0,0) after reset is not flagged by FrameStart; the first FrameStart follows a full frame.
- Reset asserted mid-frame forces the reset values on the next edge. Reset has priority over an advance in the same cycle.
- A Reset pulse of one clock is sufficient.
- Counter arithmetic is unsigned, 11 bits. No state may ever exceed H_TOTAL-1 or V_TOTAL-1.

Test Plan:
- Reset: hold Reset 3 clocks, release -> all outputs at reset values with HS=VS=1 (default polarity); CurrentX=1 after exactly 3 more clocks; PixelTick pulses every 4 clocks.
- Horizontal timing: run 2 lines -> HS low for exactly 384 clocks starting on the edge where CurrentX becomes 656; HS falling-edge period 3200 clocks; HBlank rises at CurrentX=640, falls at CurrentX=0; LineStart period 3200 clocks.
- Vertical timing (defaults, or reduced override H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=6,V_FP=1,V_SYNC=1,V_BP=1) -> default case: VS low for lines 490–491 only, VBlank high for CurrentY 480..524, frame period 1,680,000 clocks; reduced case: frame period 14*9*4 = 504 clocks.
- Wrap: observe transition from (799,524) -> next advance gives (0,0) with FrameStart, LineStart and PixelTick all high for one clock; HBlank=0, VBlank=0.
- Reset mid-operation: assert Reset for 1 clock at CurrentX=700, CurrentY=300 on an advance edge -> next cycle shows (0,0) with HS/VS inactive and no FrameStart; timing restarts cleanly.
- Polarity: SYNC_ACTIVE_LOW=0 -> HS/VS idle at 0, pulse high over the same windows; all other outputs are identical to the default run.
